// File: rtl/counter_test_sequencer_pkg.sv
// Shared encodings for the counter bank sequencer: command codes, FSM states, strobe level.
package counter_test_sequencer_pkg;

    typedef logic [1:0] cmd_t;
    typedef logic [2:0] state_t;

    localparam cmd_t CMD_CLEAR = 2'd0;
    localparam cmd_t CMD_COUNT = 2'd1;
    localparam cmd_t CMD_LOAD  = 2'd2;
    localparam cmd_t CMD_FULL  = 2'd3;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CLEAR   = 3'd1;
    localparam state_t ST_COUNT   = 3'd2;
    localparam state_t ST_LOAD_LO = 3'd3;
    localparam state_t ST_LOAD_HI = 3'd4;
    localparam state_t ST_DONE    = 3'd5;

    // Bank control strobes are active-low; this is their resting level.
    localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/counter_test_sequencer_phase_timer.sv
// Loadable down-counter shared by the CLEAR and COUNT phases; zero marks the last phase cycle.
module counter_test_sequencer_phase_timer #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // Load wins over decrement; the counter parks at zero rather than wrapping.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/counter_test_sequencer.sv
// Command-driven sequencer producing the counter bank's active-low clear/count/load strobes.
module counter_test_sequencer
    import counter_test_sequencer_pkg::*;
#(
    parameter int LOAD_W       = 4,
    parameter int LEN_W        = 4,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_start,
    input  logic [1:0]          i_cmd,
    input  logic [LEN_W-1:0]    i_count_len,
    input  logic [2*LOAD_W-1:0] i_load_data,
    input  logic                i_abort,
    output logic                o_clear_n,
    output logic                o_cnt_enable_n,
    output logic                o_ld_enable_n,
    output logic [LOAD_W-1:0]   o_load,
    output logic                o_ready,
    output logic                o_done,
    output logic [2:0]          o_state
);

    localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
    localparam int CNT_W = (LEN_W > CLR_W) ? LEN_W : CLR_W;
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYCLES - 1);

    state_t              state_q, state_nxt;
    logic                full_q;
    logic [LEN_W-1:0]    len_q;
    logic [2*LOAD_W-1:0] data_q, data_nxt;
    logic                accept;
    logic                tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0]    tmr_val;

    counter_test_sequencer_phase_timer #(.W(CNT_W)) u_timer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .dec       (tmr_dec),
        .zero      (tmr_zero)
    );

    // Timer holds (cycles remaining - 1), so a zero flag means this is the phase's last cycle.
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    accept = 1'b1;
                    case (i_cmd)
                        CMD_CLEAR, CMD_FULL: begin
                            state_nxt = ST_CLEAR;
                            tmr_load  = 1'b1;
                            tmr_val   = CLR_LAST;
                        end
                        CMD_COUNT: begin
                            if (i_count_len == '0) begin
                                state_nxt = ST_DONE;
                            end else begin
                                state_nxt = ST_COUNT;
                                tmr_load  = 1'b1;
                                tmr_val   = CNT_W'(i_count_len) - CNT_W'(1);
                            end
                        end
                        default: state_nxt = ST_LOAD_LO;
                    endcase
                end
            end
            ST_CLEAR: begin
                if (i_abort) begin
                    state_nxt = ST_IDLE;
                end else if (tmr_zero) begin
                    if (!full_q) begin
                        state_nxt = ST_DONE;
                    end else if (len_q == '0) begin
                        state_nxt = ST_LOAD_LO;
                    end else begin
                        state_nxt = ST_COUNT;
                        tmr_load  = 1'b1;
                        tmr_val   = CNT_W'(len_q) - CNT_W'(1);
                    end
                end
            end
            ST_COUNT: begin
                if (i_abort) begin
                    state_nxt = ST_IDLE;
                end else if (tmr_zero) begin
                    state_nxt = full_q ? ST_LOAD_LO : ST_DONE;
                end
            end
            ST_LOAD_LO: state_nxt = i_abort ? ST_IDLE : ST_LOAD_HI;
            ST_LOAD_HI: state_nxt = i_abort ? ST_IDLE : ST_DONE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    assign tmr_dec  = !tmr_load && ((state_q == ST_CLEAR) || (state_q == ST_COUNT));
    assign data_nxt = accept ? i_load_data : data_q;
    assign o_state  = state_q;

    // Outputs are decoded from the next state so they are registered yet line up with the state.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= ST_IDLE;
            full_q         <= 1'b0;
            len_q          <= '0;
            data_q         <= '0;
            o_clear_n      <= STROBE_OFF;
            o_cnt_enable_n <= STROBE_OFF;
            o_ld_enable_n  <= STROBE_OFF;
            o_load         <= '0;
            o_ready        <= 1'b1;
            o_done         <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (accept) begin
                full_q <= (i_cmd == CMD_FULL);
                len_q  <= i_count_len;
            end
            data_q         <= data_nxt;
            o_clear_n      <= (state_nxt == ST_CLEAR) ? ~STROBE_OFF : STROBE_OFF;
            o_cnt_enable_n <= (state_nxt == ST_COUNT) ? ~STROBE_OFF : STROBE_OFF;
            o_ld_enable_n  <= ((state_nxt == ST_LOAD_LO) || (state_nxt == ST_LOAD_HI))
                              ? ~STROBE_OFF : STROBE_OFF;
            if (state_nxt == ST_LOAD_LO) begin
                o_load <= data_nxt[LOAD_W-1:0];
            end else if (state_nxt == ST_LOAD_HI) begin
                o_load <= data_q[2*LOAD_W-1:LOAD_W];
            end else begin
                o_load <= '0;
            end
            o_ready <= (state_nxt == ST_IDLE);
            o_done  <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_counter_test_sequencer.sv
// Bench for counter_test_sequencer: directed scenarios plus random traffic against an expected-output queue.
module tb_counter_test_sequencer;
    import counter_test_sequencer_pkg::*;

    localparam int LOAD_W = 4;
    localparam int LEN_W  = 4;
    localparam int CC     = 2;
    localparam int OW     = 3 + LOAD_W + 2;

    logic                i_clk = 1'b0;
    logic                i_reset_n = 1'b1;
    logic                i_start = 1'b0;
    logic [1:0]          i_cmd = 2'd0;
    logic [LEN_W-1:0]    i_count_len = '0;
    logic [2*LOAD_W-1:0] i_load_data = '0;
    logic                i_abort = 1'b0;
    logic                o_clear_n, o_cnt_enable_n, o_ld_enable_n, o_ready, o_done;
    logic [LOAD_W-1:0]   o_load;
    logic [2:0]          o_state;

    int n_checks = 0;
    int n_errors = 0;

    // Output vector layout: [8] clear_n [7] cnt_enable_n [6] ld_enable_n [5:2] load [1] ready [0] done
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] cur;
    logic [OW-1:0] obs_v;
    localparam logic [OW-1:0] IDLE_V = {3'b111, 4'h0, 2'b10};

    assign obs_v = {o_clear_n, o_cnt_enable_n, o_ld_enable_n, o_load, o_ready, o_done};

    counter_test_sequencer #(.LOAD_W(LOAD_W), .LEN_W(LEN_W), .CLEAR_CYCLES(CC)) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_start        (i_start),
        .i_cmd          (i_cmd),
        .i_count_len    (i_count_len),
        .i_load_data    (i_load_data),
        .i_abort        (i_abort),
        .o_clear_n      (o_clear_n),
        .o_cnt_enable_n (o_cnt_enable_n),
        .o_ld_enable_n  (o_ld_enable_n),
        .o_load         (o_load),
        .o_ready        (o_ready),
        .o_done         (o_done),
        .o_state        (o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] mk(input logic c, input logic n, input logic l,
                                         input logic [LOAD_W-1:0] v, input logic r,
                                         input logic d);
        return {c, n, l, v, r, d};
    endfunction

    // Expected per-cycle outputs of one accepted command, straight from the phase rules.
    task automatic queue_cmd(input logic [1:0] cmd, input logic [LEN_W-1:0] len,
                             input logic [2*LOAD_W-1:0] data);
        exp_q.delete();
        if (cmd == CMD_CLEAR || cmd == CMD_FULL)
            for (int i = 0; i < CC; i++) exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0));
        if (cmd == CMD_COUNT || cmd == CMD_FULL)
            for (int i = 0; i < int'(len); i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0));
        if (cmd == CMD_LOAD || cmd == CMD_FULL) begin
            exp_q.push_back(mk(1'b1, 1'b1, 1'b0, data[LOAD_W-1:0], 1'b0, 1'b0));
            exp_q.push_back(mk(1'b1, 1'b1, 1'b0, data[2*LOAD_W-1:LOAD_W], 1'b0, 1'b0));
        end
        exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1));
    endtask

    task automatic cyc(input logic start, input logic [1:0] cmd, input logic [LEN_W-1:0] len,
                       input logic [2*LOAD_W-1:0] data, input logic abort, input string tag);
        i_start     = start;
        i_cmd       = cmd;
        i_count_len = len;
        i_load_data = data;
        i_abort     = abort;
        @(posedge i_clk);
        if (cur[1]) begin
            if (start) begin
                queue_cmd(cmd, len, data);
                cur = exp_q.pop_front();
            end
        end else if (abort) begin
            exp_q.delete();
            cur = IDLE_V;
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else begin
            cur = IDLE_V;
        end
        #1;
        check(tag, 32'(obs_v), 32'(cur));
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, '0, '0, 1'b0, tag);
    endtask

    // Runs one command for n cycles, tallying strobe-low cycles and the cycle o_done appears.
    task automatic run_cmd(input logic [1:0] cmd, input logic [LEN_W-1:0] len,
                           input logic [2*LOAD_W-1:0] data, input int n, input string tag,
                           output int clr, output int cnt, output int ld, output int done_at);
        clr = 0; cnt = 0; ld = 0; done_at = -1;
        for (int i = 1; i <= n; i++) begin
            if (i == 1) cyc(1'b1, cmd, len, data, 1'b0, tag);
            else        cyc(1'b0, 2'd0, '0, '0, 1'b0, tag);
            if (!o_clear_n)      clr++;
            if (!o_cnt_enable_n) cnt++;
            if (!o_ld_enable_n)  ld++;
            if (o_done && done_at < 0) done_at = i;
        end
    endtask

    initial begin
        int clr, cnt, ld, done_at;
        cur = IDLE_V;
        #1 i_reset_n = 1'b0;
        #1 check("reset_outputs", 32'(obs_v), 32'(IDLE_V));
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;

        run_cmd(CMD_COUNT, 4'd15, 8'h00, 20, "count15", clr, cnt, ld, done_at);
        check("count15_enables", cnt, 15);
        check("count15_done_at", done_at, 16);

        run_cmd(CMD_LOAD, 4'd0, 8'hC3, 5, "load_c3", clr, cnt, ld, done_at);
        check("load_c3_beats", ld, 2);
        check("load_c3_done_at", done_at, 3);

        run_cmd(CMD_FULL, 4'd4, 8'h5A, 12, "full4", clr, cnt, ld, done_at);
        check("full4_clears", clr, CC);
        check("full4_enables", cnt, 4);
        check("full4_beats", ld, 2);
        check("full4_done_at", done_at, 9);

        run_cmd(CMD_CLEAR, 4'd7, 8'h00, 5, "clear", clr, cnt, ld, done_at);
        check("clear_cycles", clr, CC);
        check("clear_done_at", done_at, CC + 1);

        run_cmd(CMD_COUNT, 4'd0, 8'h00, 3, "count0", clr, cnt, ld, done_at);
        check("count0_enables", cnt, 0);
        check("count0_done_at", done_at, 1);

        run_cmd(CMD_FULL, 4'd0, 8'h96, 7, "full0", clr, cnt, ld, done_at);
        check("full0_enables", cnt, 0);
        check("full0_done_at", done_at, CC + 3);

        // Abort in the third COUNT cycle, with a start attempted while busy.
        cyc(1'b1, CMD_COUNT, 4'd10, 8'h00, 1'b0, "abort_start");
        cyc(1'b1, CMD_LOAD, 4'd0, 8'hFF, 1'b0, "busy_start_ignored");
        cyc(1'b0, 2'd0, '0, '0, 1'b0, "abort_wait");
        cyc(1'b0, 2'd0, '0, '0, 1'b1, "abort_hit");
        check("abort_ready", 32'(o_ready), 32'(1));
        idle(3, "after_abort");
        run_cmd(CMD_LOAD, 4'd0, 8'h2B, 5, "post_abort_load", clr, cnt, ld, done_at);
        check("post_abort_done_at", done_at, 3);

        // Abort alone in IDLE is ignored; abort with start in IDLE lets the start through.
        cyc(1'b0, 2'd0, '0, '0, 1'b1, "idle_abort");
        cyc(1'b1, CMD_CLEAR, 4'd0, 8'h00, 1'b1, "start_beats_abort");
        idle(4, "start_beats_abort_tail");

        // Reset in the middle of COUNT returns outputs to rest without a clock edge.
        cyc(1'b1, CMD_COUNT, 4'd10, 8'h00, 1'b0, "reset_mid_start");
        idle(2, "reset_mid_run");
        #2 i_reset_n = 1'b0;
        #1 check("reset_mid_outputs", 32'(obs_v), 32'(IDLE_V));
        cur = IDLE_V;
        exp_q.delete();
        @(negedge i_clk);
        i_reset_n = 1'b1;
        idle(2, "after_reset");

        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                LEN_W'($urandom_range(0, 15)), 8'($urandom), ($urandom_range(0, 19) == 0),
                "random");
        end
        idle(25, "drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
